// File: rtl/blink_pattern.sv
// LED pattern engine: prescaled step rate, debounced mode button,
// four display modes (blink, shift, bounce, count).
module blink_pattern #(
  parameter int WIDTH    = 8,
  parameter int DIV_BITS = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Button,
  input  logic [DIV_BITS-1:0] Rate,
  output logic [WIDTH-1:0]    Leds,
  output logic [1:0]          Mode,
  output logic                Tick
);

  typedef enum logic [1:0] {
    BLINK  = 2'd0,
    SHIFT  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  localparam int DCW =
    (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DCW-1:0] DC_LAST =
    DCW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                deb_q, deb_d;
  logic [DCW-1:0]      dcnt_q, dcnt_d;
  logic                dir_q, dir_d;
  logic [WIDTH-1:0]    leds_q, leds_d;
  mode_e               mode_q, mode_d;
  logic                tick_q, tick_d;

  logic                step;
  logic                advance;
  logic                differ;
  logic                settled;
  logic [WIDTH-1:0]    bnc_nxt;
  logic                bnc_dir;

  always_comb begin
    differ  = (sync2_q != deb_q);
    settled = (dcnt_q == DC_LAST);
    // Only a rising debounced level advances the mode
    advance = differ & settled & sync2_q;
    step    = (cnt_q == '0);
  end

  always_comb begin
    sync1_d = Button;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    dcnt_d  = '0;
    if (differ) begin
      if (settled) begin
        deb_d = ~deb_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (step || advance) begin
      cnt_d = Rate;
    end
  end

  always_comb begin
    bnc_nxt = dir_q ? (leds_q << 1)
                    : (leds_q >> 1);
    // Turn around on the edge that lands on an end bit
    bnc_dir = dir_q ? ~bnc_nxt[WIDTH-1]
                    : bnc_nxt[0];
  end

  always_comb begin
    mode_d = mode_q;
    leds_d = leds_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (advance) begin
      mode_d = mode_e'(2'(mode_q + 2'd1));
      dir_d  = 1'b1;
      unique case (mode_d)
        SHIFT, BOUNCE: leds_d = ONE;
        default:       leds_d = '0;
      endcase
    end else if (step) begin
      tick_d = 1'b1;
      unique case (mode_q)
        BLINK:  leds_d = ~leds_q;
        SHIFT:  leds_d = {leds_q[WIDTH-2:0],
                          leds_q[WIDTH-1]};
        BOUNCE: begin
          leds_d = bnc_nxt;
          dir_d  = bnc_dir;
        end
        COUNT:  leds_d = leds_q + ONE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= Rate;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      dir_q   <= 1'b1;
      leds_q  <= '0;
      mode_q  <= BLINK;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      dir_q   <= dir_d;
      leds_q  <= leds_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  assign Leds = leds_q;
  assign Mode = mode_q;
  assign Tick = tick_q;

endmodule
